// File: rtl/tdm_demux4.sv
// TDM demultiplexer: rebuilds SLOTS-bit frames from a slot-scanned serial stream,
// aligned by a slot-0 sync marker, with frame counting and sync-error detection.
module tdm_demux4 #(
  parameter int SLOTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din,
  input  logic                       en,
  input  logic                       sync,
  output logic [$clog2(SLOTS)-1:0]   sel,
  output logic [SLOTS-1:0]           q,
  output logic                       frame_valid,
  output logic                       sync_err,
  output logic [7:0]                 frame_cnt
);

  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SLOTS-1:0] shadow_q, shadow_d;
  logic [SLOTS-1:0] data_q, data_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d    = '0;
            shadow_d[0] = din;
            sel_d       = SW'(1);
            state_d     = RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and restarts.
            err_d       = (sel_q != '0);
            shadow_d    = '0;
            shadow_d[0] = din;
            sel_d       = SW'(1);
          end else if (sel_q == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            shadow_d[sel_q] = din;
            if (sel_q == LAST_SLOT) begin
              data_d = shadow_d;
              fv_d   = 1'b1;
              cnt_d  = cnt_q + 8'd1;
              sel_d  = '0;
            end else begin
              sel_d = sel_q + SW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign sel         = sel_q;
  assign q           = data_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign frame_cnt   = cnt_q;

endmodule
